// File: rtl/ex_seq_stage.sv
// ex_seq_stage: sequenced execute stage for the lc3b pipeline.
// Computes ALU results and effective addresses, expands LDI/STI into a
// pointer read followed by the final access, and presents results in a
// registered valid/ready output slot toward the memory stage.
// Optional feature macro: EX_SEQ_ITER_MUL_EN (iterative shift-add MUL for
// class 5; when undefined class 5 completes in one cycle with result=sr1).
module ex_seq_stage #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LSHF_AMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cls,
  input  logic [2:0]       in_aluop,
  input  logic [WIDTH-1:0] in_npc,
  input  logic [WIDTH-1:0] in_sr1,
  input  logic [WIDTH-1:0] in_sr2,
  input  logic [WIDTH-1:0] in_off,
  input  logic             in_addr1_sel,
  input  logic             in_lshf,
  input  logic [2:0]       in_dr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic             out_ptr,
  output logic [WIDTH-1:0] out_addr,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_wdata,
  output logic [2:0]       out_dr,
  input  logic             ind_valid,
  input  logic [WIDTH-1:0] ind_data
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  localparam logic [2:0] CLS_LD  = 3'd1;
  localparam logic [2:0] CLS_ST  = 3'd2;
  localparam logic [2:0] CLS_LDI = 3'd3;
  localparam logic [2:0] CLS_STI = 3'd4;
  localparam logic [2:0] CLS_MUL = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;

  localparam logic [1:0] KIND_ALU   = 2'd0;
  localparam logic [1:0] KIND_READ  = 2'd1;
  localparam logic [1:0] KIND_WRITE = 2'd2;

`ifdef EX_SEQ_ITER_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {S_IDLE, S_PTR, S_WAIT, S_FINAL, S_MUL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PTR, S_WAIT, S_FINAL} state_t;
`endif

  state_t           r_state;
  logic             r_out_valid;
  logic [1:0]       r_out_kind;
  logic             r_out_ptr;
  logic [WIDTH-1:0] r_out_addr;
  logic [WIDTH-1:0] r_out_result;
  logic [WIDTH-1:0] r_out_wdata;
  logic [2:0]       r_out_dr;
  logic [WIDTH-1:0] r_sr2;
  logic             r_final_wr;
  logic [WIDTH-1:0] r_ind_data;
`ifdef EX_SEQ_ITER_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
`endif

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_ea;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_slot_free;
  logic             w_accept;

  assign w_base      = in_addr1_sel ? in_sr1 : in_npc;
  assign w_off       = in_lshf ? (in_off << LSHF_AMT) : in_off;
  assign w_ea        = w_base + w_off;
  assign w_shamt     = in_sr2[SH_W-1:0];
  assign w_slot_free = !r_out_valid | out_ready;
  assign in_ready    = rst_n & !flush & (r_state == S_IDLE) & w_slot_free;
  assign w_accept    = in_valid & in_ready;

  assign out_valid  = r_out_valid;
  assign out_kind   = r_out_kind;
  assign out_ptr    = r_out_ptr;
  assign out_addr   = r_out_addr;
  assign out_result = r_out_result;
  assign out_wdata  = r_out_wdata;
  assign out_dr     = r_out_dr;

  // Single-cycle ALU result; class 5 falls back to sr1 when MUL is not built
  always_comb begin
    w_alu_res = in_sr1;
    case (in_aluop)
      OP_ADD:  w_alu_res = in_sr1 + in_sr2;
      OP_AND:  w_alu_res = in_sr1 & in_sr2;
      OP_NOT:  w_alu_res = ~in_sr1;
      OP_SLL:  w_alu_res = in_sr1 << w_shamt;
      OP_SRL:  w_alu_res = in_sr1 >> w_shamt;
      OP_SRA:  w_alu_res = WIDTH'($signed(in_sr1) >>> w_shamt);
      default: w_alu_res = in_sr1;
    endcase
    if (in_cls == CLS_MUL) w_alu_res = in_sr1;
  end

  // Sequencer FSM and output slot; flush overrides all other activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_out_kind   <= KIND_ALU;
      r_out_ptr    <= 1'b0;
      r_out_addr   <= '0;
      r_out_result <= '0;
      r_out_wdata  <= '0;
      r_out_dr     <= '0;
      r_sr2        <= '0;
      r_final_wr   <= 1'b0;
      r_ind_data   <= '0;
`ifdef EX_SEQ_ITER_MUL_EN
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
`endif
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out_dr  <= in_dr;
            r_out_ptr <= 1'b0;
            case (in_cls)
              CLS_LD: begin
                r_out_valid <= 1'b1;
                r_out_kind  <= KIND_READ;
                r_out_addr  <= w_ea;
              end
              CLS_ST: begin
                r_out_valid <= 1'b1;
                r_out_kind  <= KIND_WRITE;
                r_out_addr  <= w_ea;
                r_out_wdata <= in_sr2;
              end
              CLS_LDI, CLS_STI: begin
                r_out_valid <= 1'b1;
                r_out_kind  <= KIND_READ;
                r_out_ptr   <= 1'b1;
                r_out_addr  <= w_ea;
                r_sr2       <= in_sr2;
                r_final_wr  <= (in_cls == CLS_STI);
                r_state     <= S_PTR;
              end
`ifdef EX_SEQ_ITER_MUL_EN
              CLS_MUL: begin
                r_out_valid <= 1'b0;
                r_mcand     <= in_sr1;
                r_mplier    <= in_sr2;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_state     <= S_MUL;
              end
`endif
              default: begin
                r_out_valid  <= 1'b1;
                r_out_kind   <= KIND_ALU;
                r_out_result <= w_alu_res;
              end
            endcase
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_PTR: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ind_valid) begin
            r_ind_data <= ind_data;
            r_state    <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_kind  <= r_final_wr ? KIND_WRITE : KIND_READ;
            r_out_ptr   <= 1'b0;
            r_out_addr  <= r_ind_data;
            r_out_wdata <= r_sr2;
            r_state     <= S_IDLE;
          end
        end
`ifdef EX_SEQ_ITER_MUL_EN
        S_MUL: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_out_valid  <= 1'b1;
            r_out_kind   <= KIND_ALU;
            r_out_ptr    <= 1'b0;
            r_out_result <= r_acc;
            r_state      <= S_IDLE;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_seq_stage.sv
// Bench for ex_seq_stage: reset, table vectors, LDI/STI/MUL sequences and a
// randomized run against a behavioural model of the output slot.
module tb_ex_seq_stage;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned LSHF_AMT = 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_cls;
  logic [2:0]       in_aluop;
  logic [WIDTH-1:0] in_npc, in_sr1, in_sr2, in_off;
  logic             in_addr1_sel;
  logic             in_lshf;
  logic [2:0]       in_dr;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_kind;
  logic             out_ptr;
  logic [WIDTH-1:0] out_addr, out_result, out_wdata;
  logic [2:0]       out_dr;
  logic             ind_valid;
  logic [WIDTH-1:0] ind_data;

  ex_seq_stage #(.WIDTH(WIDTH), .LSHF_AMT(LSHF_AMT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_aluop(in_aluop),
    .in_npc(in_npc), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_off(in_off),
    .in_addr1_sel(in_addr1_sel), .in_lshf(in_lshf), .in_dr(in_dr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_ptr(out_ptr),
    .out_addr(out_addr), .out_result(out_result), .out_wdata(out_wdata),
    .out_dr(out_dr), .ind_valid(ind_valid), .ind_data(ind_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]       cls;
    logic [2:0]       aluop;
    logic [WIDTH-1:0] npc, sr1, sr2, off;
    logic             sel, lshf;
    logic [2:0]       dr;
    logic [1:0]       kind;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] wdata;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic [2:0] cls, input logic [2:0] aluop,
                       input logic [WIDTH-1:0] npc, input logic [WIDTH-1:0] sr1,
                       input logic [WIDTH-1:0] sr2, input logic [WIDTH-1:0] off,
                       input logic sel, input logic lshf, input logic [2:0] dr);
    in_cls = cls; in_aluop = aluop; in_npc = npc; in_sr1 = sr1;
    in_sr2 = sr2; in_off = off; in_addr1_sel = sel; in_lshf = lshf; in_dr = dr;
  endtask

  // Reference: plain integer arithmetic from the architectural rules
  function automatic void ref_op(input logic [2:0] cls, input logic [2:0] aluop,
                                 input logic [WIDTH-1:0] npc, input logic [WIDTH-1:0] sr1,
                                 input logic [WIDTH-1:0] sr2, input logic [WIDTH-1:0] off,
                                 input logic sel, input logic lshf,
                                 output logic [1:0] kind, output logic [WIDTH-1:0] val,
                                 output logic [WIDTH-1:0] wdata);
    longint mask, a, b, ea, o, r, sa;
    int sh;
    mask = (longint'(1) << WIDTH) - 1;
    a  = longint'(sr1);
    b  = longint'(sr2);
    o  = longint'(off);
    if (lshf) o = o * (longint'(1) << LSHF_AMT);
    ea = ((sel ? a : longint'(npc)) + o) & mask;
    sh = int'(sr2) % WIDTH;
    case (aluop)
      3'd0: r = a + b;
      3'd1: r = a & b;
      3'd2: r = mask - a;
      3'd4: r = a * (longint'(1) << sh);
      3'd5: r = a / (longint'(1) << sh);
      3'd6: begin
        sa = (a >= (longint'(1) << (WIDTH - 1))) ? a - (mask + 1) : a;
        r  = sa >>> sh;
      end
      default: r = a;
    endcase
    if (cls == 3'd5) r = a;
    r = r & mask;
    wdata = sr2;
    if (cls == 3'd1) begin kind = 2'd1; val = WIDTH'(ea); end
    else if (cls == 3'd2) begin kind = 2'd2; val = WIDTH'(ea); end
    else begin kind = 2'd0; val = WIDTH'(r); end
  endfunction

  task automatic chk_slot(input string tag, input logic [1:0] kind,
                          input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] wdata,
                          input logic [2:0] dr);
    chk({tag, ".valid"}, WIDTH'(out_valid), WIDTH'(1));
    chk({tag, ".kind"}, WIDTH'(out_kind), WIDTH'(kind));
    chk({tag, ".ptr"}, WIDTH'(out_ptr), WIDTH'(0));
    chk({tag, ".dr"}, WIDTH'(out_dr), WIDTH'(dr));
    if (kind == 2'd0) chk({tag, ".result"}, out_result, val);
    else              chk({tag, ".addr"}, out_addr, val);
    if (kind == 2'd2) chk({tag, ".wdata"}, out_wdata, wdata);
  endtask

  initial begin
    logic             m_valid;
    logic [1:0]       m_kind;
    logic [WIDTH-1:0] m_val, m_wdata;
    logic [2:0]       m_dr;
    logic [1:0]       k;
    logic [WIDTH-1:0] v, w;
    logic             exp_rdy;
    logic [2:0]       rc;

    vecs[0]  = '{3'd0, 3'd0, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd1, 2'd0, 16'h8000, 16'h0000};
    vecs[1]  = '{3'd0, 3'd6, 16'h0000, 16'h8000, 16'h0003, 16'h0000, 1'b0, 1'b0, 3'd2, 2'd0, 16'hF000, 16'h0000};
    vecs[2]  = '{3'd1, 3'd0, 16'h3000, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b1, 3'd3, 2'd1, 16'h2FFC, 16'h0000};
    vecs[3]  = '{3'd2, 3'd0, 16'h0000, 16'h1234, 16'hBEEF, 16'h0010, 1'b1, 1'b0, 3'd4, 2'd2, 16'h1244, 16'hBEEF};
    vecs[4]  = '{3'd0, 3'd1, 16'h0000, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 3'd5, 2'd0, 16'h3030, 16'h0000};
    vecs[5]  = '{3'd0, 3'd2, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd6, 2'd0, 16'hFF00, 16'h0000};
    vecs[6]  = '{3'd0, 3'd4, 16'h0000, 16'h0001, 16'h0013, 16'h0000, 1'b0, 1'b0, 3'd7, 2'd0, 16'h0008, 16'h0000};
    vecs[7]  = '{3'd0, 3'd5, 16'h0000, 16'h8000, 16'h000F, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0001, 16'h0000};
    vecs[8]  = '{3'd0, 3'd3, 16'h0000, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 1'b0, 3'd1, 2'd0, 16'hABCD, 16'h0000};
    vecs[9]  = '{3'd0, 3'd7, 16'h0000, 16'h1357, 16'h2222, 16'h0000, 1'b0, 1'b0, 3'd2, 2'd0, 16'h1357, 16'h0000};
    vecs[10] = '{3'd6, 3'd0, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 1'b0, 3'd3, 2'd0, 16'h0001, 16'h0000};
    vecs[11] = '{3'd1, 3'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0, 3'd4, 2'd1, 16'h0000, 16'h0000};
    vecs[12] = '{3'd2, 3'd0, 16'h0002, 16'h0000, 16'h5A5A, 16'hFFFF, 1'b0, 1'b1, 3'd5, 2'd2, 16'h0000, 16'h5A5A};

    // Reset with in_valid held high
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; ind_valid = 1'b0; ind_data = '0;
    in_valid = 1'b1;
    drive(3'd0, 3'd0, 16'h0, 16'h1, 16'h1, 16'h0, 1'b0, 1'b0, 3'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst.out_valid", WIDTH'(out_valid), WIDTH'(0));
      chk("rst.in_ready", WIDTH'(in_ready), WIDTH'(0));
    end
    chk("rst.kind", WIDTH'(out_kind), WIDTH'(0));
    chk("rst.ptr", WIDTH'(out_ptr), WIDTH'(0));
    chk("rst.addr", out_addr, WIDTH'(0));
    chk("rst.result", out_result, WIDTH'(0));
    chk("rst.wdata", out_wdata, WIDTH'(0));
    chk("rst.dr", WIDTH'(out_dr), WIDTH'(0));
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst.release_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("rst.release_valid", WIDTH'(out_valid), WIDTH'(0));

    // Table vectors issued back-to-back with out_ready held high
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].cls, vecs[i].aluop, vecs[i].npc, vecs[i].sr1, vecs[i].sr2,
            vecs[i].off, vecs[i].sel, vecs[i].lshf, vecs[i].dr);
      in_valid = 1'b1;
      #1 chk($sformatf("vec%0d.in_ready", i), WIDTH'(in_ready), WIDTH'(1));
      @(negedge clk);
      chk_slot($sformatf("vec%0d", i), vecs[i].kind, vecs[i].val, vecs[i].wdata, vecs[i].dr);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain.valid", WIDTH'(out_valid), WIDTH'(0));

    // LDI with the pointer request stalled for 3 cycles
    drive(3'd3, 3'd0, 16'h0, 16'h4000, 16'h9999, 16'h0008, 1'b1, 1'b1, 3'd5);
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ldi.ptr_valid", WIDTH'(out_valid), WIDTH'(1));
      chk("ldi.ptr_kind", WIDTH'(out_kind), WIDTH'(1));
      chk("ldi.ptr_flag", WIDTH'(out_ptr), WIDTH'(1));
      chk("ldi.ptr_addr", out_addr, 16'h4010);
      chk("ldi.in_ready", WIDTH'(in_ready), WIDTH'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("ldi.wait_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("ldi.wait_ready", WIDTH'(in_ready), WIDTH'(0));
    ind_valid = 1'b1; ind_data = 16'h5000;
    @(negedge clk);
    ind_valid = 1'b0; ind_data = 16'h0BAD;
    chk("ldi.final_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("ldi.final_ready", WIDTH'(in_ready), WIDTH'(0));
    @(negedge clk);
    chk("ldi.valid", WIDTH'(out_valid), WIDTH'(1));
    chk("ldi.kind", WIDTH'(out_kind), WIDTH'(1));
    chk("ldi.addr", out_addr, 16'h5000);
    chk("ldi.ptr", WIDTH'(out_ptr), WIDTH'(0));
    chk("ldi.dr", WIDTH'(out_dr), WIDTH'(5));
    @(negedge clk);
    chk("ldi.drained", WIDTH'(out_valid), WIDTH'(0));

    // STI flushed while waiting for pointer data
    drive(3'd4, 3'd0, 16'h1000, 16'h0, 16'hCAFE, 16'h0020, 1'b0, 1'b0, 3'd2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("sti.ptr_flag", WIDTH'(out_ptr), WIDTH'(1));
    chk("sti.ptr_addr", out_addr, 16'h1020);
    @(negedge clk);
    chk("sti.wait_valid", WIDTH'(out_valid), WIDTH'(0));
    flush = 1'b1;
    #1 chk("sti.flush_ready", WIDTH'(in_ready), WIDTH'(0));
    @(negedge clk);
    flush = 1'b0;
    #1 chk("sti.idle_ready", WIDTH'(in_ready), WIDTH'(1));
    ind_valid = 1'b1; ind_data = 16'h6000;
    @(negedge clk);
    ind_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sti.no_write", WIDTH'(out_valid), WIDTH'(0));
      chk("sti.ready", WIDTH'(in_ready), WIDTH'(1));
      @(negedge clk);
    end

`ifdef EX_SEQ_ITER_MUL_EN
    // Iterative multiply: result appears WIDTH+1 cycles after accept
    drive(3'd5, 3'd0, 16'h0, 16'h0012, 16'h0034, 16'h0, 1'b0, 1'b0, 3'd3);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c < 17) begin
        chk($sformatf("mul.busy%0d", c), WIDTH'(out_valid), WIDTH'(0));
        chk($sformatf("mul.ready%0d", c), WIDTH'(in_ready), WIDTH'(0));
        @(negedge clk);
      end else begin
        chk("mul.valid", WIDTH'(out_valid), WIDTH'(1));
        chk("mul.kind", WIDTH'(out_kind), WIDTH'(0));
        chk("mul.result", out_result, 16'h03A8);
        chk("mul.dr", WIDTH'(out_dr), WIDTH'(3));
      end
    end
    @(negedge clk);
    // Multiply aborted by a flush in its fifth cycle
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("mulflush.no_out", WIDTH'(out_valid), WIDTH'(0));
      @(negedge clk);
    end
    chk("mulflush.ready", WIDTH'(in_ready), WIDTH'(1));
`endif

    // Randomized single-cycle ops against the slot model
    m_valid = 1'b0; m_kind = '0; m_val = '0; m_wdata = '0; m_dr = '0;
    for (int n = 0; n < 300; n++) begin
      if (m_valid) chk_slot("rnd", m_kind, m_val, m_wdata, m_dr);
      else         chk("rnd.empty", WIDTH'(out_valid), WIDTH'(0));
      rc = 3'($urandom_range(0, 5));
      if (rc == 3'd3) rc = 3'd6;
      if (rc == 3'd4) rc = 3'd7;
`ifdef EX_SEQ_ITER_MUL_EN
      if (rc == 3'd5) rc = 3'd0;
`endif
      drive(rc, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      exp_rdy   = !flush && (!m_valid || out_ready);
      #1 chk("rnd.in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
      if (flush) m_valid = 1'b0;
      else if (in_valid && exp_rdy) begin
        ref_op(in_cls, in_aluop, in_npc, in_sr1, in_sr2, in_off, in_addr1_sel,
               in_lshf, k, v, w);
        m_valid = 1'b1; m_kind = k; m_val = v; m_wdata = w; m_dr = in_dr;
      end else if (out_ready) m_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_seq_stage.md
# ex_seq_stage

Parametrised, sequenced execute stage for the lc3b pipeline. It computes ALU results and effective addresses for one instruction at a time. It expands indirect loads and stores (LDI/STI) into a pointer read followed by a final access, driven by an internal FSM instead of bubble injection. Results sit in a registered output slot with a valid/ready handshake toward the memory stage. A flush input from branch resolution kills in-flight work.

## Interface
- WIDTH, 16: datapath width (data, addresses, offsets).
- LSHF_AMT, 1: left shift applied to the offset when `in_lshf`=1 (word scaling).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  kill in-flight op and output slot.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle (handshake = in_valid & in_ready).
- in_cls  in  3  class: 0 ALU, 1 LD, 2 ST, 3 LDI, 4 STI, 5 MUL; 6–7 treated as ALU.
- in_aluop  in  3  0 ADD, 1 AND, 2 NOT, 3 PASS, 4 SLL, 5 SRL, 6 SRA, 7 PASS.
- in_npc, in_sr1, in_sr2, in_off  in  WIDTH  operands; `in_off` is pre-sign-extended by decode.
- in_addr1_sel  in  1  address base: 0 npc, 1 sr1.
- in_lshf  in  1  shift offset by LSHF_AMT.
- in_dr  in  3  destination register tag, passed through.
- out_valid  out  1  output slot full.
- out_ready  in  1  memory stage consumes the slot.
- out_kind  out  2  0 ALU, 1 READ, 2 WRITE.
- out_ptr  out  1  this READ is an indirect pointer fetch; not a register write.
- out_addr, out_result, out_wdata  out  WIDTH  address, ALU/MUL result, store data.
- out_dr  out  3  destination tag.
- ind_valid  in  1  pointer data returned from memory stage.
- ind_data  in  WIDTH  pointer value.

## Operation
- FSM states: IDLE, PTR (pointer request in slot), WAIT (awaiting `ind_valid`), FINAL (final access pending), MUL.
- `in_ready` = !flush & state==IDLE & (!out_valid | out_ready).
- Address (ALU, LD, ST, LDI, STI): ea = base + (in_lshf ? in_off<<LSHF_AMT : in_off), modulo 2^WIDTH.
- ALU: result per `in_aluop`. Shift amount is in_sr2[$clog2(WIDTH)-1:0]. SRA replicates the MSB.
- ALU accepted: slot loads kind=ALU, result, dr. LD loads kind=READ, addr=ea. ST loads kind=WRITE, addr=ea, wdata=sr2. State stays IDLE.
- LDI/STI accepted: slot loads kind=READ, out_ptr=1, addr=ea. The latched sr2 and final kind are held internally. State goes to PTR.
- PTR: when the slot is consumed (out_ready), go to WAIT with out_valid=0.
- WAIT: on `ind_valid`, go to FINAL. `ind_valid` is ignored in every other state.
- FINAL: when the slot is free, load kind = READ (LDI) or WRITE (STI), addr=ind_data (latched), wdata=latched sr2, out_ptr=0. Return to IDLE.
- Slot holds its contents stable while out_valid & !out_ready.
- flush: next edge sets state=IDLE and out_valid=0. Flush overrides any concurrent accept, ind_valid or MUL step.
- Reset values: state IDLE, out_valid 0, in_ready 0 during reset, out_kind 0, out_ptr 0, out_addr/out_result/out_wdata 0, out_dr 0.

## Timing
- ALU/LD/ST: 1 cycle from accept to out_valid.
- LDI/STI: pointer request 1 cycle after accept. Final access 1 cycle after the `ind_valid` edge, or later if the slot is still occupied.
- MUL (macro enabled): WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout.
- Back-to-back ALU ops sustain 1 per cycle when out_ready is held high.
- A flush asserted in the same cycle as out_ready: the slot is dropped, not double-counted.

## Configuration
- EX_SEQ_ITER_MUL_EN defined: class 5 enters state MUL. A shift-add iterative multiplier runs one bit per cycle for WIDTH cycles, then emits kind=ALU with result=(sr1*sr2) low WIDTH bits.
- EX_SEQ_ITER_MUL_EN undefined: class 5 executes as a 1-cycle ALU op with result=sr1. The MUL state and its counter are absent.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1. Required: out_valid=0 and in_ready=0 throughout. After release, in_ready=1 within 1 cycle.
- ALU stream, WIDTH=16: ADD 0x7FFF+0x0001, then SRA 0x8000 by 3, with out_ready=1. Required: results 0x8000 then 0xF000 on consecutive cycles.
- LD: addr1_sel=0, npc=0x3000, off=0xFFFE, lshf=1. Required: out_kind=READ, out_addr=0x2FFC.
- LDI with out_ready stalled 3 cycles: pointer read at ea=0x4010 with out_ptr=1, held stable. Then ind_valid with 0x5000. Required: READ addr=0x5000, out_ptr=0, in_ready=0 until it issues.
- STI with flush asserted in WAIT: state returns to IDLE, no WRITE is issued, and a later ind_valid is ignored.
- MUL (macro defined): 0x0012*0x0034. Required: result 0x03A8 after 17 cycles. Flush at cycle 5 aborts with no output.
